// File: rtl/mul_div_ctrl.sv
`default_nettype none
// ============================================================================
// mul_div_ctrl : HI/LO multiply/divide unit with fixed-latency multiply,
//                radix-2 restoring divide, cancel and mthi/mtlo writes.
// Revision     : 1.0
// ============================================================================
module mul_div_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mdOp,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        cancel,
  input  logic        hiWe,
  input  logic        loWe,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [4:0] C_MUL_LOAD = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] C_DIV_LOAD = 5'd31;

  logic [1:0]  r_state, w_next;
  logic [4:0]  r_cnt;
  logic        r_sgn, r_dz, r_ovf, r_neg_q, r_neg_r;
  logic [31:0] r_a, r_b, r_quo, r_rem, r_div;
  logic [31:0] r_hi, r_lo;

  logic        w_accept, w_sgn_in, w_dz_in, w_ovf_in;
  logic [31:0] w_abs1, w_abs2;
  logic [63:0] w_a_ext, w_b_ext, w_prod;
  logic [32:0] w_shift;
  logic [33:0] w_diff;
  logic [31:0] w_res_hi, w_res_lo;

  assign w_accept = (r_state == S_IDLE) && start && !cancel;
  assign w_sgn_in = ~mdOp[0];
  assign w_dz_in  = (din2 == 32'd0);
  assign w_ovf_in = (mdOp == 2'b00) && (din1 == 32'h8000_0000) && (din2 == 32'hFFFF_FFFF);
  assign w_abs1   = (w_sgn_in && din1[31]) ? (~din1 + 32'd1) : din1;
  assign w_abs2   = (w_sgn_in && din2[31]) ? (~din2 + 32'd1) : din2;

  // Sign-extending to 64 bits makes the truncated product correct for both mult and multu.
  assign w_a_ext = {{32{r_sgn & r_a[31]}}, r_a};
  assign w_b_ext = {{32{r_sgn & r_b[31]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_div};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (mdOp[1])                w_next = S_MUL;
        else if (w_dz_in || w_ovf_in) w_next = S_FIX;
        else                        w_next = S_DIV;
      end
      S_MUL:   if (cancel || r_cnt == 5'd0) w_next = S_IDLE;
      S_DIV:   if (cancel) w_next = S_IDLE; else if (r_cnt == 5'd0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = !cancel && (((r_state == S_MUL) && (r_cnt == 5'd0)) || (r_state == S_FIX));
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    if (r_state == S_FIX) begin
      if (r_dz) begin
        w_res_hi = r_a;
        w_res_lo = 32'hFFFF_FFFF;
      end else if (r_ovf) begin
        w_res_hi = 32'd0;
        w_res_lo = 32'h8000_0000;
      end else begin
        w_res_hi = r_neg_r ? (~r_rem + 32'd1) : r_rem;
        w_res_lo = r_neg_q ? (~r_quo + 32'd1) : r_quo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 5'd0;
      r_sgn   <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_quo   <= 32'd0;
      r_rem   <= 32'd0;
      r_div   <= 32'd0;
    end else if (w_accept) begin
      r_cnt   <= mdOp[1] ? C_MUL_LOAD : C_DIV_LOAD;
      r_sgn   <= w_sgn_in;
      r_dz    <= w_dz_in;
      r_ovf   <= w_ovf_in;
      r_neg_q <= w_sgn_in && (din1[31] ^ din2[31]);
      r_neg_r <= w_sgn_in && din1[31];
      r_a     <= din1;
      r_b     <= din2;
      r_quo   <= w_abs1;
      r_rem   <= 32'd0;
      r_div   <= w_abs2;
    end else if (r_state == S_MUL) begin
      if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
    end else if (r_state == S_DIV) begin
      if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
      // Restore by keeping the shifted partial remainder when the trial subtract borrows.
      if (w_diff[33]) begin
        r_rem <= w_shift[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end else begin
        r_rem <= w_diff[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (done) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if ((r_state == S_IDLE) && !start) begin
      if (hiWe) r_hi <= wdata;
      if (loWe) r_lo <= wdata;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mul_div_ctrl : directed self-checking bench for mul_div_ctrl.
// Revision        : 1.0
// ============================================================================
module tb_mul_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mdOp = 2'b00;
  logic [31:0] din1 = 32'd0;
  logic [31:0] din2 = 32'd0;
  logic        cancel = 1'b0;
  logic        hiWe = 1'b0;
  logic        loWe = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mul_div_ctrl #(.MUL_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mdOp(mdOp), .din1(din1), .din2(din2),
    .cancel(cancel), .hiWe(hiWe), .loWe(loWe), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation and returns the cycle (relative to start) in which done pulsed.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int maxc, output int dcyc, output int bcnt);
    mdOp = op; din1 = a; din2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    dcyc = -1;
    bcnt = 0;
    for (int k = 1; k <= maxc; k++) begin
      if (busy) bcnt++;
      if (done && dcyc < 0) dcyc = k;
      tick();
      if (dcyc >= 0) break;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
  endtask

  task automatic test_mult();
    int d, b;
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, d, b);
    checks++; if (d !== 4) begin errors++; $display("FAIL multu_done_cycle got %0d want 4", d); end
    checks++; if (b !== 4) begin errors++; $display("FAIL multu_busy_cycles got %0d want 4", b); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_after got %0b want 0", busy); end
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 20, d, b);
    checks++; if (d !== 4) begin errors++; $display("FAIL mult_done_cycle got %0d want 4", d); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h want fffffff1", lo); end
  endtask

  task automatic test_div();
    int d, b;
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 50, d, b);
    checks++; if (d !== 33) begin errors++; $display("FAIL div_done_cycle got %0d want 33", d); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_2_hi got %h want ffffffff", hi); end
    run_op(2'b01, 32'd100, 32'd7, 50, d, b);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_100_7_lo got %h want 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_100_7_hi got %h want 00000002", hi); end
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 50, d, b);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_7_m2_hi got %h want 00000001", hi); end
    run_op(2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 50, d, b);
    checks++; if (lo !== 32'd2) begin errors++; $display("FAIL div_m8_m3_lo got %h want 00000002", lo); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL div_m8_m3_hi got %h want fffffffe", hi); end
    run_op(2'b01, 32'hFFFF_FFFF, 32'd16, 50, d, b);
    checks++; if (lo !== 32'h0FFF_FFFF) begin errors++; $display("FAIL divu_big_lo got %h want 0fffffff", lo); end
    checks++; if (hi !== 32'd15) begin errors++; $display("FAIL divu_big_hi got %h want 0000000f", hi); end
  endtask

  task automatic test_special();
    int d, b;
    run_op(2'b01, 32'd5, 32'd0, 10, d, b);
    checks++; if (d !== 1) begin errors++; $display("FAIL divu_zero_done_cycle got %0d want 1", d); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo got %h want ffffffff", lo); end
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL divu_zero_hi got %h want 00000005", hi); end
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 10, d, b);
    checks++; if (d !== 1) begin errors++; $display("FAIL div_ovf_done_cycle got %0d want 1", d); end
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
    run_op(2'b00, 32'hFFFF_FFFB, 32'd0, 10, d, b);
    checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div_zero_neg_hi got %h want fffffffb", hi); end
  endtask

  task automatic test_cancel();
    int seen;
    hiWe = 1'b1; wdata = 32'hAAAA_AAAA; tick(); hiWe = 1'b0;
    loWe = 1'b1; wdata = 32'h5555_5555; tick(); loWe = 1'b0;
    mdOp = 2'b10; din1 = 32'hFFFF_FFFD; din2 = 32'd5; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    cancel = 1'b1; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cancel_busy_before got %0b want 1", busy); end
    tick(); cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy_after got %0b want 0", busy); end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL cancel_no_done got %0d pulses want 0", seen); end
    checks++; if (hi !== 32'hAAAA_AAAA) begin errors++; $display("FAIL cancel_hi got %h want aaaaaaaa", hi); end
    checks++; if (lo !== 32'h5555_5555) begin errors++; $display("FAIL cancel_lo got %h want 55555555", lo); end
    // Cancel landing on the completion cycle wins over the result write.
    mdOp = 2'b01; din1 = 32'd5; din2 = 32'd0; start = 1'b1;
    tick(); start = 1'b0;
    cancel = 1'b1; #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL cancel_fix_done got %0b want 0", done); end
    tick(); cancel = 1'b0;
    checks++; if (hi !== 32'hAAAA_AAAA) begin errors++; $display("FAIL cancel_fix_hi got %h want aaaaaaaa", hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_fix_busy got %0b want 0", busy); end
    cancel = 1'b1; mdOp = 2'b01; din1 = 32'd9; din2 = 32'd0; start = 1'b1;
    tick(); start = 1'b0; cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_start_idle got busy %0b want 0", busy); end
  endtask

  task automatic test_writes();
    int d;
    mdOp = 2'b01; din1 = 32'd100; din2 = 32'd7; start = 1'b1;
    tick(); start = 1'b0;
    hiWe = 1'b1; wdata = 32'h1234_5678;
    tick(); hiWe = 1'b0;
    checks++; if (hi !== 32'hAAAA_AAAA) begin errors++; $display("FAIL busy_write_hi got %h want aaaaaaaa", hi); end
    d = 0;
    while (busy && d < 60) begin tick(); d++; end
    checks++; if (hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL busy_write_result got %h/%h want 00000002/0000000e", hi, lo); end
    hiWe = 1'b1; wdata = 32'h1234_5678;
    tick(); hiWe = 1'b0;
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL idle_write_hi got %h want 12345678", hi); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL idle_write_lo_kept got %h want 0000000e", lo); end
    hiWe = 1'b1; loWe = 1'b1; wdata = 32'hCAFE_F00D;
    tick(); hiWe = 1'b0; loWe = 1'b0;
    checks++; if (hi !== 32'hCAFE_F00D || lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL both_write got %h/%h want cafef00d/cafef00d", hi, lo); end
    mdOp = 2'b01; din1 = 32'd9; din2 = 32'd0; start = 1'b1; hiWe = 1'b1; wdata = 32'd0;
    tick(); start = 1'b0; hiWe = 1'b0;
    checks++; if (hi !== 32'hCAFE_F00D) begin errors++; $display("FAIL start_wins_hi got %h want cafef00d", hi); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL start_wins_done got %0b want 1", done); end
    tick();
    checks++; if (hi !== 32'd9 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL start_wins_result got %h/%h want 00000009/ffffffff", hi, lo); end
    // A second start while multiplying must not disturb the running operation.
    mdOp = 2'b11; din1 = 32'd6; din2 = 32'd7; start = 1'b1;
    tick();
    mdOp = 2'b01; din1 = 32'd5; din2 = 32'd0;
    d = -1;
    for (int k = 1; k <= 10; k++) begin
      if (done && d < 0) d = k;
      tick();
      start = 1'b0;
      if (d >= 0) break;
    end
    start = 1'b0;
    checks++; if (d !== 4) begin errors++; $display("FAIL start_busy_done_cycle got %0d want 4", d); end
    checks++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL start_busy_result got %h/%h want 00000000/0000002a", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int d, b;
    run_op(2'b11, 32'd3, 32'd4, 20, d, b);
    checks++; if (busy !== 1'b0 || lo !== 32'd12) begin errors++; $display("FAIL b2b_first got busy %0b lo %h want 0/0000000c", busy, lo); end
    run_op(2'b01, 32'd100, 32'd7, 50, d, b);
    checks++; if (d !== 33) begin errors++; $display("FAIL b2b_done_cycle got %0d want 33", d); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL b2b_result got %h/%h want 00000002/0000000e", hi, lo); end
  endtask

  task automatic test_async_reset();
    int d, b;
    mdOp = 2'b01; din1 = 32'd100; din2 = 32'd7; start = 1'b1;
    tick(); start = 1'b0;
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %0b want 0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL async_rst_hilo got %h/%h want 0/0", hi, lo); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 20, d, b);
    checks++; if (d !== 4) begin errors++; $display("FAIL post_rst_done_cycle got %0d want 4", d); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL post_rst_result got %h/%h want ffffffff/fffffff1", hi, lo); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_mult();
    test_div();
    test_special();
    test_cancel();
    test_writes();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
